// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry, hazard hold,
// flush, occupancy reporting and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int DATA_W     = 128,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Encoding is {main valid, skid valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  main_data_reg, main_data_next;
    logic [DATA_W-1:0]  skid_data_reg, skid_data_next;
    logic [CNT_W-1:0]   bubble_cnt_reg;
    logic               main_valid, skid_valid;
    logic               push, pop;

    assign main_valid = state_reg[1];
    assign skid_valid = state_reg[0];

    generate
        if (SKID != 0) begin : g_skid
            // Registered-only readiness: no path from out_ready.
            assign in_ready = ~skid_valid & ~hold & ~flush & Rst_n;
        end else begin : g_noskid
            assign in_ready = (~main_valid | out_ready) & ~hold & ~flush & Rst_n;
        end
    endgenerate

    assign out_valid  = main_valid & ~hold & ~flush;
    assign out_data   = main_data_reg;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
    assign bubble_cnt = bubble_cnt_reg;

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            state_next = EMPTY;
            if (CLEAR_DATA != 0) begin
                main_data_next = '0;
                skid_data_next = '0;
            end
        end else if (!hold) begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        state_next     = ONE;
                        main_data_next = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data_next = in_data;
                    end else if (push && (SKID != 0)) begin
                        state_next     = FULL;
                        skid_data_next = in_data;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next     = ONE;
                        main_data_next = skid_data_reg;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            skid_data_reg <= skid_data_next;
        end
    end

    // Flush leaves the bubble count alone; only reset clears it.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            bubble_cnt_reg <= '0;
        end else if (hold && main_valid && !flush && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (A) and a no-skid, CLEAR_DATA=0,
// 2-bit counter instance (B), checked by directed tasks and a queue model.
module tb_pipe_stage_reg;
    localparam int W = 32;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic rst_n;

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_hold, a_flush;
    logic [W-1:0]  a_in_data, a_out_data;
    logic [1:0]    a_occupancy;
    logic [15:0]   a_bubble_cnt;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hold, b_flush;
    logic [W-1:0]  b_in_data, b_out_data;
    logic [1:0]    b_occupancy;
    logic [1:0]    b_bubble_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.DATA_W(W), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) dut_a (
        .Clk(Clk), .Rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .hold(a_hold), .flush(a_flush),
        .occupancy(a_occupancy), .bubble_cnt(a_bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(W), .SKID(0), .CLEAR_DATA(0), .CNT_W(2)) dut_b (
        .Clk(Clk), .Rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .hold(b_hold), .flush(b_flush),
        .occupancy(b_occupancy), .bubble_cnt(b_bubble_cnt)
    );

    // Reference model: an ordered queue of held payloads with a capacity rule.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_data;
    int           m_bub;
    int           m_cntmax;
    bit           m_skid;
    bit           m_clear;

    function automatic bit mdl_in_ready(bit ordy, bit h, bit f);
        if (h || f) return 1'b0;
        if (m_skid) return mq.size() < 2;
        return (mq.size() == 0) || ordy;
    endfunction

    function automatic bit mdl_out_valid(bit h, bit f);
        return (mq.size() > 0) && !h && !f;
    endfunction

    task automatic mdl_step(input bit iv, input logic [W-1:0] d, input bit ordy,
                            input bit h, input bit f,
                            output bit popped, output logic [W-1:0] pd);
        bit ir, ov;
        ir = mdl_in_ready(ordy, h, f);
        ov = mdl_out_valid(h, f);
        popped = 1'b0;
        pd = '0;
        if (f) begin
            mq.delete();
            if (m_clear) m_data = '0;
        end else if (h) begin
            if (mq.size() > 0 && m_bub < m_cntmax) m_bub++;
        end else begin
            if (ov && ordy) begin
                popped = 1'b1;
                pd = mq.pop_front();
            end
            if (iv && ir) mq.push_back(d);
            if (mq.size() > 0) m_data = mq[0];
        end
    endtask

    task automatic idle_all();
        a_in_valid = 0; a_out_ready = 0; a_hold = 0; a_flush = 0; a_in_data = '0;
        b_in_valid = 0; b_out_ready = 0; b_hold = 0; b_flush = 0; b_in_data = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%0b exp=0", a_in_ready); end
        rst_n = 1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got=%0b exp=1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got=%0b exp=0", a_out_valid); end
        checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_a_out_data got=%h exp=0", a_out_data); end
        checks++; if (a_occupancy !== 2'd0) begin errors++; $display("FAIL reset_a_occupancy got=%0d exp=0", a_occupancy); end
        checks++; if (a_bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_a_bubble got=%0d exp=0", a_bubble_cnt); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready got=%0b exp=1", b_in_ready); end
        checks++; if (b_occupancy !== 2'd0) begin errors++; $display("FAIL reset_b_occupancy got=%0d exp=0", b_occupancy); end
        $display("reset: released");
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            a_in_valid = 1; a_in_data = W'(k); a_out_ready = 1;
            #1;
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got=%0b exp=1", k, a_in_ready); end
            if (k > 1) begin
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== W'(k - 1)) begin errors++; $display("FAIL stream_out k=%0d got=%0b/%0d exp=1/%0d", k, a_out_valid, a_out_data, k - 1); end
                checks++; if (a_occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ k=%0d got=%0d exp=1", k, a_occupancy); end
            end else begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got=%0b exp=0", a_out_valid); end
            end
            $display("stream: push %0d", k);
        end
        @(negedge Clk);
        a_in_valid = 0;
        #1;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'd5) begin errors++; $display("FAIL stream_last got=%0b/%0d exp=1/5", a_out_valid, a_out_data); end
        @(negedge Clk);
        a_out_ready = 0;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain got=%0b/%0d exp=0/0", a_out_valid, a_occupancy); end
    endtask

    task automatic test_backpressure();
        @(negedge Clk);
        a_in_valid = 1; a_in_data = 32'hA; a_out_ready = 0;
        @(negedge Clk);
        a_in_data = 32'hB;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got=%0b exp=1", a_in_ready); end
        @(negedge Clk);
        a_in_valid = 0;
        #1;
        checks++; if (a_occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ_full got=%0d exp=2", a_occupancy); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%0b exp=0", a_in_ready); end
        checks++; if (a_out_data !== 32'hA || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_head_a got=%0b/%h exp=1/a", a_out_valid, a_out_data); end
        a_out_ready = 1;
        @(negedge Clk);
        #1;
        checks++; if (a_out_data !== 32'hB || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_head_b got=%0b/%h exp=1/b", a_out_valid, a_out_data); end
        checks++; if (a_in_ready !== 1'b1 || a_occupancy !== 2'd1) begin errors++; $display("FAIL bp_after_pop got=%0b/%0d exp=1/1", a_in_ready, a_occupancy); end
        @(negedge Clk);
        a_out_ready = 0;
        #1;
        checks++; if (a_occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty got=%0d exp=0", a_occupancy); end
        $display("backpressure: A then B delivered");
    endtask

    task automatic test_hold();
        @(negedge Clk);
        a_in_valid = 1; a_in_data = 32'h55; a_out_ready = 0;
        @(negedge Clk);
        a_in_valid = 0; a_hold = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL hold_flags k=%0d got=%0b/%0b exp=0/0", k, a_out_valid, a_in_ready); end
            checks++; if (a_out_data !== 32'h55 || a_bubble_cnt !== 16'(k)) begin errors++; $display("FAIL hold_state k=%0d got=%h/%0d exp=55/%0d", k, a_out_data, a_bubble_cnt, k); end
            @(negedge Clk);
        end
        a_hold = 0; a_out_ready = 1;
        #1;
        checks++; if (a_bubble_cnt !== 16'd3) begin errors++; $display("FAIL hold_bubble got=%0d exp=3", a_bubble_cnt); end
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h55) begin errors++; $display("FAIL hold_release got=%0b/%h exp=1/55", a_out_valid, a_out_data); end
        @(negedge Clk);
        a_out_ready = 0;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_occupancy !== 2'd0) begin errors++; $display("FAIL hold_once got=%0b/%0d exp=0/0", a_out_valid, a_occupancy); end
        $display("hold: 0x55 delivered after 3 bubbles");
    endtask

    task automatic test_flush();
        @(negedge Clk);
        a_in_valid = 1; a_in_data = 32'h11; a_out_ready = 0;
        @(negedge Clk);
        a_in_data = 32'h22;
        @(negedge Clk);
        a_in_data = 32'h33; a_flush = 1;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_flags got=%0b/%0b exp=0/0", a_out_valid, a_in_ready); end
        @(negedge Clk);
        a_flush = 0; a_in_valid = 0;
        #1;
        checks++; if (a_occupancy !== 2'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got=%0d/%0b exp=0/0", a_occupancy, a_out_valid); end
        checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL flush_data got=%h exp=0", a_out_data); end
        checks++; if (a_bubble_cnt !== 16'd3) begin errors++; $display("FAIL flush_keeps_bubble got=%0d exp=3", a_bubble_cnt); end
        $display("flush: FULL discarded");
    endtask

    task automatic test_random_skid();
        bit popped;
        logic [W-1:0] pd;
        m_skid = 1; m_clear = 1; m_cntmax = 65535;
        mq.delete(); m_data = '0; m_bub = 3;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge Clk);
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_hold      = ($urandom_range(0, 7) == 0);
            a_flush     = ($urandom_range(0, 15) == 0);
            a_in_data   = $urandom;
            #1;
            checks++; if (a_in_ready !== mdl_in_ready(a_out_ready, a_hold, a_flush)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%0b", cyc, a_in_ready); end
            checks++; if (a_out_valid !== mdl_out_valid(a_hold, a_flush)) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%0b", cyc, a_out_valid); end
            checks++; if (a_out_data !== m_data) begin errors++; $display("FAIL rnd_out_data cyc=%0d got=%h exp=%h", cyc, a_out_data, m_data); end
            checks++; if (a_occupancy !== 2'(mq.size())) begin errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, a_occupancy, mq.size()); end
            checks++; if (a_bubble_cnt !== 16'(m_bub)) begin errors++; $display("FAIL rnd_bubble cyc=%0d got=%0d exp=%0d", cyc, a_bubble_cnt, m_bub); end
            mdl_step(a_in_valid, a_in_data, a_out_ready, a_hold, a_flush, popped, pd);
            if (popped) $display("random: cyc=%0d pop %h", cyc, pd);
        end
        @(negedge Clk);
        a_in_valid = 0; a_out_ready = 0; a_hold = 0; a_flush = 0;
    endtask

    task automatic test_skid0_toggle();
        bit popped;
        logic [W-1:0] pd;
        int next_seq, exp_seq, pops;
        m_skid = 0; m_clear = 0; m_cntmax = 3;
        mq.delete(); m_data = '0; m_bub = 0;
        next_seq = 1; exp_seq = 1; pops = 0;
        for (int cyc = 0; cyc < 1000 && pops < 100; cyc++) begin
            @(negedge Clk);
            b_in_valid = 1; b_in_data = W'(next_seq); b_out_ready = ((cyc % 2) == 0);
            #1;
            checks++; if (b_in_ready !== mdl_in_ready(b_out_ready, 1'b0, 1'b0)) begin errors++; $display("FAIL tog_in_ready cyc=%0d got=%0b", cyc, b_in_ready); end
            checks++; if (b_out_valid !== mdl_out_valid(1'b0, 1'b0)) begin errors++; $display("FAIL tog_out_valid cyc=%0d got=%0b", cyc, b_out_valid); end
            if (b_out_valid && b_out_ready) begin
                checks++; if (b_out_data !== W'(exp_seq)) begin errors++; $display("FAIL tog_order got=%0d exp=%0d", b_out_data, exp_seq); end
                $display("toggle: pop %0d", b_out_data);
                exp_seq++; pops++;
            end
            if (mdl_in_ready(b_out_ready, 1'b0, 1'b0)) next_seq++;
            mdl_step(b_in_valid, b_in_data, b_out_ready, 1'b0, 1'b0, popped, pd);
        end
        checks++; if (pops != 100) begin errors++; $display("FAIL tog_count got=%0d exp=100", pops); end
    endtask

    task automatic test_saturation();
        @(negedge Clk);
        b_in_valid = 0; b_out_ready = 1;
        repeat (2) @(negedge Clk);
        b_in_valid = 1; b_in_data = 32'hAB; b_out_ready = 0;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL sat_ready got=%0b exp=1", b_in_ready); end
        @(negedge Clk);
        b_in_valid = 0; b_hold = 1;
        for (int k = 0; k <= 6; k++) begin
            #1;
            checks++; if (b_bubble_cnt !== 2'((k > 3) ? 3 : k)) begin errors++; $display("FAIL sat_bubble k=%0d got=%0d exp=%0d", k, b_bubble_cnt, (k > 3) ? 3 : k); end
            if (k < 6) @(negedge Clk);
        end
        b_hold = 0; b_flush = 1;
        #1;
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin errors++; $display("FAIL sat_flush_flags got=%0b/%0b exp=0/0", b_out_valid, b_in_ready); end
        @(negedge Clk);
        b_flush = 0;
        #1;
        checks++; if (b_occupancy !== 2'd0 || b_out_data !== 32'hAB) begin errors++; $display("FAIL noclear_flush got=%0d/%h exp=0/ab", b_occupancy, b_out_data); end
        checks++; if (b_bubble_cnt !== 2'd3) begin errors++; $display("FAIL sat_after_flush got=%0d exp=3", b_bubble_cnt); end
        $display("saturation: bubble_cnt held at 3");
    endtask

    task automatic test_reset_mid_full();
        @(negedge Clk);
        a_flush = 1;
        @(negedge Clk);
        a_flush = 0; a_in_valid = 1; a_in_data = 32'hC1; a_out_ready = 0;
        @(negedge Clk);
        a_in_data = 32'hC2;
        @(negedge Clk);
        a_in_valid = 0;
        #1;
        checks++; if (a_occupancy !== 2'd2) begin errors++; $display("FAIL rst_pre_full got=%0d exp=2", a_occupancy); end
        rst_n = 0; a_in_valid = 1; a_in_data = 32'hC3; a_out_ready = 1;
        @(negedge Clk);
        rst_n = 1; a_in_valid = 0; a_out_ready = 0;
        #1;
        checks++; if (a_occupancy !== 2'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_empty got=%0d/%0b exp=0/0", a_occupancy, a_out_valid); end
        checks++; if (a_out_data !== 32'h0 || a_bubble_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_regs got=%h/%0d exp=0/0", a_out_data, a_bubble_cnt); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%0b exp=1", a_in_ready); end
        checks++; if (b_bubble_cnt !== 2'd0) begin errors++; $display("FAIL rst_b_bubble got=%0d exp=0", b_bubble_cnt); end
        $display("reset: mid-FULL reset cleared stage");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_hold();
        test_flush();
        test_random_skid();
        test_skid0_toggle();
        test_saturation();
        test_reset_mid_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
